// File: rtl/botao_debounce_counter.sv
// Debounced key -> event counter -> single-address req/ack memory write port.
// Optional hold-repeat timer is compiled in when BTN_AUTO_REPEAT_EN is defined.
module botao_debounce_counter #(
    parameter int unsigned           DATA_WIDTH      = 32,
    parameter int unsigned           ADDR_WIDTH      = 12,
    parameter logic [ADDR_WIDTH-1:0] WR_ADDR         = {ADDR_WIDTH{1'b0}},
    parameter int unsigned           DEBOUNCE_CYCLES = 50000,
    parameter bit                    BTN_ACTIVE_LOW  = 1'b1,
    parameter int unsigned           REPEAT_CYCLES   = 25000000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  btn_raw,
    input  logic                  cnt_clr,
    output logic                  btn_level,
    output logic                  press_pulse,
    output logic [DATA_WIDTH-1:0] count,
    output logic                  wr_req,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_ack
);

    localparam int unsigned      DBC_W        = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DBC_W-1:0] DBC_MAX      = DBC_W'(DEBOUNCE_CYCLES - 1);
    localparam logic             RAW_RELEASED = BTN_ACTIVE_LOW;

    if (DEBOUNCE_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_bad_params
        $error("botao_debounce_counter: DEBOUNCE_CYCLES and REPEAT_CYCLES must be >= 2");
    end

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_PRESSED      = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } state_e;

    state_e                state_q, state_d;
    logic                  sync1_q, sync1_d;
    logic                  sync2_q, sync2_d;
    logic [DBC_W-1:0]      dbc_q, dbc_d;
    logic                  btn_level_q, btn_level_d;
    logic                  press_pulse_q, press_pulse_d;
    logic [DATA_WIDTH-1:0] count_q, count_d;
    logic                  cnt_upd_q, cnt_upd_d;
    logic                  wr_req_q, wr_req_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;

    logic s_btn;
    logic dbc_done;
    logic press_acc;
    logic rpt_fire;

    // Synchronizer, polarity fix and debounce counter next-state.
    always_comb begin
        sync1_d  = btn_raw;
        sync2_d  = sync1_q;
        s_btn    = BTN_ACTIVE_LOW ? ~sync2_q : sync2_q;
        dbc_done = (s_btn != btn_level_q) && (dbc_q == DBC_MAX);
        if (s_btn == btn_level_q) begin
            dbc_d       = {DBC_W{1'b0}};
            btn_level_d = btn_level_q;
        end else if (dbc_done) begin
            dbc_d       = {DBC_W{1'b0}};
            btn_level_d = ~btn_level_q;
        end else begin
            dbc_d       = dbc_q + DBC_W'(1);
            btn_level_d = btn_level_q;
        end
    end

    // Synchronizer and debounce registers; sync flops reset to the released level.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q     <= RAW_RELEASED;
            sync2_q     <= RAW_RELEASED;
            dbc_q       <= {DBC_W{1'b0}};
            btn_level_q <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            dbc_q       <= dbc_d;
            btn_level_q <= btn_level_d;
        end
    end

    // Key FSM next-state: a press is accepted only when the debounce count completes.
    always_comb begin
        state_d   = state_q;
        press_acc = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (s_btn) begin
                    state_d = ST_PRESS_WAIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PRESS_WAIT: begin
                if (!s_btn) begin
                    state_d = ST_IDLE;
                end else if (dbc_done) begin
                    state_d   = ST_PRESSED;
                    press_acc = 1'b1;
                end else begin
                    state_d = ST_PRESS_WAIT;
                end
            end
            ST_PRESSED: begin
                if (!s_btn) begin
                    state_d = ST_RELEASE_WAIT;
                end else begin
                    state_d = ST_PRESSED;
                end
            end
            ST_RELEASE_WAIT: begin
                if (s_btn) begin
                    state_d = ST_PRESSED;
                end else if (dbc_done) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RELEASE_WAIT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

`ifdef BTN_AUTO_REPEAT_EN
    localparam int unsigned      RPT_W   = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
    localparam logic [RPT_W-1:0] RPT_MAX = RPT_W'(REPEAT_CYCLES - 1);

    logic [RPT_W-1:0] rpt_q, rpt_d;

    // Repeat timer: runs only while staying in PRESSED, so entry always starts from zero.
    always_comb begin
        rpt_d    = {RPT_W{1'b0}};
        rpt_fire = 1'b0;
        if ((state_q == ST_PRESSED) && s_btn) begin
            if (rpt_q == RPT_MAX) begin
                rpt_fire = 1'b1;
                rpt_d    = {RPT_W{1'b0}};
            end else begin
                rpt_d = rpt_q + RPT_W'(1);
            end
        end else begin
            rpt_d = {RPT_W{1'b0}};
        end
    end

    // Repeat timer register.
    always_ff @(posedge clk) begin
        if (reset) begin
            rpt_q <= {RPT_W{1'b0}};
        end else begin
            rpt_q <= rpt_d;
        end
    end
`else
    assign rpt_fire = 1'b0;
`endif

    // Event counter and write port: clear beats a press; a newer count overrides a pending write.
    always_comb begin
        press_pulse_d = press_acc | rpt_fire;
        if (cnt_clr) begin
            count_d   = {DATA_WIDTH{1'b0}};
            cnt_upd_d = 1'b1;
        end else if (press_pulse_d) begin
            count_d   = count_q + DATA_WIDTH'(1);
            cnt_upd_d = 1'b1;
        end else begin
            count_d   = count_q;
            cnt_upd_d = 1'b0;
        end
        wr_req_d  = wr_req_q;
        wr_data_d = wr_data_q;
        if (cnt_upd_q) begin
            wr_req_d  = 1'b1;
            wr_data_d = count_q;
        end else if (wr_req_q && wr_ack) begin
            wr_req_d = 1'b0;
        end else begin
            wr_req_d  = wr_req_q;
            wr_data_d = wr_data_q;
        end
    end

    // Counter and write-port registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            press_pulse_q <= 1'b0;
            count_q       <= {DATA_WIDTH{1'b0}};
            cnt_upd_q     <= 1'b0;
            wr_req_q      <= 1'b0;
            wr_data_q     <= {DATA_WIDTH{1'b0}};
        end else begin
            press_pulse_q <= press_pulse_d;
            count_q       <= count_d;
            cnt_upd_q     <= cnt_upd_d;
            wr_req_q      <= wr_req_d;
            wr_data_q     <= wr_data_d;
        end
    end

    assign btn_level   = btn_level_q;
    assign press_pulse = press_pulse_q;
    assign count       = count_q;
    assign wr_req      = wr_req_q;
    assign wr_addr     = WR_ADDR;
    assign wr_data     = wr_data_q;

endmodule
